// File: rtl/rr_encoder_arbiter.sv
// Four-way round-robin arbiter with registered one-hot grant, encoded index (q) and valid (v).
// Optional forced release after MAX_HOLD grant cycles when ARB_TIMEOUT_EN is defined.
module rr_encoder_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] gnt,
    output logic [1:0]      q,
    output logic            v,
    output logic            timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] w_c;
    logic       found_c;
    logic       owner_rel_c;
    logic       release_c;

    // First set request bit searched from ptr upward, wrapping mod 4
    always_comb begin
        logic [1:0] idx;
        w_c     = ptr;
        found_c = 1'b0;
        idx     = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                w_c     = idx;
                found_c = 1'b1;
            end
        end
    end

    assign owner_rel_c = done | ~req[q];

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt;
    logic       force_c;

    // A normal release on the same cycle wins, so timeout stays low then
    assign force_c   = (hold_cnt == HOLD_LAST) & ~owner_rel_c;
    assign release_c = owner_rel_c | force_c;
`else
    logic unused_max_hold;

    assign unused_max_hold = ^8'(MAX_HOLD);
    assign release_c       = owner_rel_c;
    assign timeout         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 2'd0;
            gnt   <= '0;
            q     <= 2'd0;
            v     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            timeout  <= 1'b0;
            hold_cnt <= 8'd0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (found_c) begin
                        gnt   <= NREQ'(1) << w_c;
                        q     <= w_c;
                        v     <= 1'b1;
                        state <= GRANT;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt <= 8'd0;
`endif
                    end
                end
                GRANT: begin
                    // Released owner drops to lowest priority for the next round
                    if (release_c) begin
                        gnt   <= '0;
                        q     <= 2'd0;
                        v     <= 1'b0;
                        ptr   <= q + 2'd1;
                        state <= IDLE;
`ifdef ARB_TIMEOUT_EN
                        timeout <= force_c;
`endif
                    end
`ifdef ARB_TIMEOUT_EN
                    else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Directed-vector bench for rr_encoder_arbiter: per-cycle table plus hold/timeout sequences.
module tb_rr_encoder_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] q;
    logic       v;
    logic       timeout;

    int checks;
    int failures;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic [1:0] q;
        logic       v;
    } vec_t;

    vec_t vecs[$];

    rr_encoder_arbiter #(.NREQ(4), .MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .q       (q),
        .v       (v),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [3:0] rq, input logic d,
                       input logic [3:0] g, input logic [1:0] qq, input logic vv);
        vec_t e;
        e.rst_n = r; e.req = rq; e.done = d; e.gnt = g; e.q = qq; e.v = vv;
        vecs.push_back(e);
    endtask

    task automatic check(input string name, input int step, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%b required=%b", name, step, act, exp);
        end
    endtask

    // Apply inputs, clock once, then compare the registered outputs just after the edge
    task automatic step(input logic r, input logic [3:0] rq, input logic d, input string name, input int idx,
                        input logic [3:0] eg, input logic [1:0] eq, input logic ev, input logic et);
        rst_n = r; req = rq; done = d;
        @(posedge clk);
        #1;
        check({name, "_gnt"}, idx, gnt, eg);
        check({name, "_q"}, idx, {2'b00, q}, {2'b00, eq});
        check({name, "_v"}, idx, {3'b000, v}, {3'b000, ev});
        check({name, "_timeout"}, idx, {3'b000, timeout}, {3'b000, et});
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0; req = 4'b0000; done = 1'b0;

        // reset held with all requesting, then idle
        add(0, 4'b1111, 0, 4'b0000, 2'd0, 0);
        add(0, 4'b1111, 0, 4'b0000, 2'd0, 0);
        add(0, 4'b1111, 0, 4'b0000, 2'd0, 0);
        add(1, 4'b0000, 0, 4'b0000, 2'd0, 0);
        // rotation 0,1,2,3,0 with done every grant cycle
        add(1, 4'b1111, 0, 4'b0001, 2'd0, 1);
        add(1, 4'b1111, 1, 4'b0000, 2'd0, 0);
        add(1, 4'b1111, 0, 4'b0010, 2'd1, 1);
        add(1, 4'b1111, 1, 4'b0000, 2'd0, 0);
        add(1, 4'b1111, 0, 4'b0100, 2'd2, 1);
        add(1, 4'b1111, 1, 4'b0000, 2'd0, 0);
        add(1, 4'b1111, 0, 4'b1000, 2'd3, 1);
        add(1, 4'b1111, 1, 4'b0000, 2'd0, 0);
        add(1, 4'b1111, 0, 4'b0001, 2'd0, 1);
        add(1, 4'b1111, 1, 4'b0000, 2'd0, 0);
        // single requester 2, done three cycles after grant, then ptr=3
        add(1, 4'b0100, 0, 4'b0100, 2'd2, 1);
        add(1, 4'b0100, 0, 4'b0100, 2'd2, 1);
        add(1, 4'b0100, 0, 4'b0100, 2'd2, 1);
        add(1, 4'b0100, 1, 4'b0000, 2'd0, 0);
        add(1, 4'b1111, 0, 4'b1000, 2'd3, 1);
        // reset mid-grant returns ptr to 0
        add(0, 4'b1111, 0, 4'b0000, 2'd0, 0);
        add(1, 4'b1001, 0, 4'b0001, 2'd0, 1);
        add(1, 4'b1001, 1, 4'b0000, 2'd0, 0);
        // drop-out release, other req bits ignored during grant, done in IDLE ignored
        add(1, 4'b0010, 0, 4'b0010, 2'd1, 1);
        add(1, 4'b0110, 0, 4'b0010, 2'd1, 1);
        add(1, 4'b0000, 0, 4'b0000, 2'd0, 0);
        add(1, 4'b0000, 1, 4'b0000, 2'd0, 0);
        add(1, 4'b0000, 1, 4'b0000, 2'd0, 0);
        add(1, 4'b1011, 0, 4'b1000, 2'd3, 1);
        // done and req drop together: single pointer advance to 0
        add(1, 4'b0011, 1, 4'b0000, 2'd0, 0);
        add(1, 4'b0011, 0, 4'b0001, 2'd0, 1);
        // released requester re-granted when alone
        add(1, 4'b0001, 1, 4'b0000, 2'd0, 0);
        add(1, 4'b0001, 0, 4'b0001, 2'd0, 1);
        add(1, 4'b0000, 0, 4'b0000, 2'd0, 0);

        foreach (vecs[i])
            step(vecs[i].rst_n, vecs[i].req, vecs[i].done, "vec", i,
                 vecs[i].gnt, vecs[i].q, vecs[i].v, 1'b0);

        // ptr is now 1; requester 0 holds without done
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++)
            step(1, 4'b0001, 0, "to_hold", i, 4'b0001, 2'd0, 1, 0);
        step(1, 4'b0001, 0, "to_force", 0, 4'b0000, 2'd0, 0, 1);
        step(1, 4'b0011, 0, "to_next", 0, 4'b0010, 2'd1, 1, 0);
        for (int i = 0; i < 3; i++)
            step(1, 4'b0011, 0, "to_hold2", i, 4'b0010, 2'd1, 1, 0);
        step(1, 4'b0011, 1, "to_normal_wins", 0, 4'b0000, 2'd0, 0, 0);
`else
        for (int i = 0; i < 40; i += 1)
            step(1, 4'b0001, 0, "long_hold", i, 4'b0001, 2'd0, 1, 0);
        step(1, 4'b0001, 1, "long_release", 0, 4'b0000, 2'd0, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
